// File: rtl/p_dispatch_mw_pkg.sv
// Shared dispatch-stage types: rename->dispatch, dispatch->ROB, dispatch->issue and CDB packets.
// Also holds the execution-port ids and the buffered-entry layout.
package a_defines;
    localparam int XLEN   = 32;
    localparam int PREG_W = 6;
    localparam int AREG_W = 5;
    localparam int PORT_W = 2;

    localparam logic [PORT_W-1:0] PORT_ALU = 2'd0;
    localparam logic [PORT_W-1:0] PORT_LSU = 2'd1;
    localparam logic [PORT_W-1:0] PORT_MDU = 2'd2;

    typedef struct packed {
        logic [PORT_W-1:0]      port;
        logic [AREG_W-1:0]      areg;
        logic [PREG_W-1:0]      preg;
        logic [1:0][PREG_W-1:0] src_preg;
        logic [XLEN-1:0]        pc;
        logic                   w_reg;
        logic                   w_mem;
    } rename_dispatch_pkg_t;

    typedef struct packed {
        logic              issue;
        logic [AREG_W-1:0] areg;
        logic [PREG_W-1:0] preg;
        logic [XLEN-1:0]   pc;
        logic              w_reg;
        logic              w_mem;
    } dispatch_rob_pkg_t;

    typedef struct packed {
        logic [PORT_W-1:0]    port;
        logic [AREG_W-1:0]    areg;
        logic [PREG_W-1:0]    preg;
        logic [XLEN-1:0]      pc;
        logic                 w_reg;
        logic                 w_mem;
        logic [1:0][XLEN-1:0] src_data;
        logic [1:0]           src_rdy;
    } dispatch_issue_pkg_t;

    typedef struct packed {
        logic [PREG_W-1:0] w_preg;
        logic [XLEN-1:0]   w_data;
        logic              w_valid;
    } cdb_dispatch_pkg_t;

    typedef struct packed {
        rename_dispatch_pkg_t inst;
        logic [1:0][XLEN-1:0] src_data;
        logic [1:0]           src_rdy;
    } dispatch_entry_t;
endpackage

// File: rtl/p_dispatch_wakeup.sv
// One source tag compared against every CDB lane; the lowest-numbered matching lane supplies data.
module p_dispatch_wakeup
    import a_defines::*;
#(
    parameter int NCDB = 2
) (
    input  logic [PREG_W-1:0]                src_preg_i,
    input  cdb_dispatch_pkg_t [NCDB-1:0]     cdb_i,
    output logic                             hit_o,
    output logic [XLEN-1:0]                  data_o
);
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        for (int l = NCDB - 1; l >= 0; l--) begin
            if (cdb_i[l].w_valid && (cdb_i[l].w_preg == src_preg_i)) begin
                hit_o  = 1'b1;
                data_o = cdb_i[l].w_data;
            end
        end
    end
endmodule

// File: rtl/p_dispatch_mw.sv
// Multi-way in-order dispatch buffer: compacting enqueue, CDB wakeup with bypass,
// and in-order issue of up to WAYS entries to distinct execution ports per cycle.
module p_dispatch_mw
    import a_defines::*;
#(
    parameter int WAYS  = 2,
    parameter int DEPTH = 8,
    parameter int NPORT = 3,
    parameter int NCDB  = 2
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   flush_i,
    input  logic [WAYS-1:0]                        in_valid_i,
    input  rename_dispatch_pkg_t [WAYS-1:0]        in_pkg_i,
    output logic                                   in_ready_o,
    input  logic [WAYS-1:0][1:0][XLEN-1:0]         rob_data_i,
    input  logic [WAYS-1:0][1:0]                   rob_complete_i,
    input  cdb_dispatch_pkg_t [NCDB-1:0]           cdb_i,
    output dispatch_rob_pkg_t [WAYS-1:0]           dispatch_rob_o,
    output logic [NPORT-1:0]                       out_valid_o,
    input  logic [NPORT-1:0]                       out_ready_i,
    output dispatch_issue_pkg_t [NPORT-1:0]        out_pkg_o
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d, count_q, count_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    dispatch_entry_t  entry_q [DEPTH];
    dispatch_entry_t  entry_d [DEPTH];
    logic [WAYS-1:0]  fire;
    logic             do_enq;

    logic            buf_hit  [DEPTH][2];
    logic [XLEN-1:0] buf_data [DEPTH][2];
    logic            enq_hit  [WAYS][2];
    logic [XLEN-1:0] enq_data [WAYS][2];

    // Buffered compares serve both the registered wakeup and the output bypass.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_buf
        for (genvar gj = 0; gj < 2; gj++) begin : g_src
            p_dispatch_wakeup #(.NCDB(NCDB)) u_wk (
                .src_preg_i (entry_q[gi].inst.src_preg[gj]),
                .cdb_i      (cdb_i),
                .hit_o      (buf_hit[gi][gj]),
                .data_o     (buf_data[gi][gj])
            );
        end
    end

    for (genvar gi = 0; gi < WAYS; gi++) begin : g_enq
        for (genvar gj = 0; gj < 2; gj++) begin : g_src
            p_dispatch_wakeup #(.NCDB(NCDB)) u_wk (
                .src_preg_i (in_pkg_i[gi].src_preg[gj]),
                .cdb_i      (cdb_i),
                .hit_o      (enq_hit[gi][gj]),
                .data_o     (enq_data[gi][gj])
            );
        end
    end

    assign in_ready_o = ((PTR_W'(DEPTH) - count_q) >= PTR_W'(WAYS)) && !flush_i;
    assign do_enq     = in_ready_o && !rst && (|in_valid_i);

    // Walk the oldest entries; the chain breaks at the first entry that is not presented or does not fire.
    always_comb begin
        logic             chain;
        logic [NPORT-1:0] claimed;
        logic [IDX_W-1:0] idx;
        dispatch_entry_t  e;
        chain       = !flush_i && !rst;
        claimed     = '0;
        fire        = '0;
        out_valid_o = '0;
        out_pkg_o   = '0;
        for (int k = 0; k < WAYS; k++) begin
            idx = head_q[IDX_W-1:0] + IDX_W'(k);
            e   = entry_q[idx];
            if (chain && (PTR_W'(k) < count_q)) begin
                chain = 1'b0;
                for (int p = 0; p < NPORT; p++) begin
                    if ((e.inst.port == PORT_W'(p)) && !claimed[p]) begin
                        claimed[p]          = 1'b1;
                        out_valid_o[p]      = 1'b1;
                        fire[k]             = out_ready_i[p];
                        chain               = out_ready_i[p];
                        out_pkg_o[p].port   = e.inst.port;
                        out_pkg_o[p].areg   = e.inst.areg;
                        out_pkg_o[p].preg   = e.inst.preg;
                        out_pkg_o[p].pc     = e.inst.pc;
                        out_pkg_o[p].w_reg  = e.inst.w_reg;
                        out_pkg_o[p].w_mem  = e.inst.w_mem;
                        for (int s = 0; s < 2; s++) begin
                            out_pkg_o[p].src_rdy[s]  = e.src_rdy[s] | buf_hit[idx][s];
                            out_pkg_o[p].src_data[s] = e.src_rdy[s] ? e.src_data[s] : buf_data[idx][s];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        int               enq_n;
        int               fire_n;
        logic [IDX_W-1:0] idx;
        entry_d        = entry_q;
        valid_d        = valid_q;
        dispatch_rob_o = '0;
        enq_n          = 0;
        fire_n         = 0;
        idx            = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int s = 0; s < 2; s++) begin
                if (valid_q[i] && !entry_q[i].src_rdy[s] && buf_hit[i][s]) begin
                    entry_d[i].src_rdy[s]  = 1'b1;
                    entry_d[i].src_data[s] = buf_data[i][s];
                end
            end
        end
        for (int w = 0; w < WAYS; w++) begin
            if (do_enq && in_valid_i[w]) begin
                idx                    = tail_q[IDX_W-1:0] + IDX_W'(enq_n);
                enq_n                  = enq_n + 1;
                valid_d[idx]           = 1'b1;
                entry_d[idx].inst      = in_pkg_i[w];
                for (int s = 0; s < 2; s++) begin
                    entry_d[idx].src_rdy[s]  = rob_complete_i[w][s] | enq_hit[w][s];
                    entry_d[idx].src_data[s] = rob_complete_i[w][s] ? rob_data_i[w][s]
                                             : (enq_hit[w][s] ? enq_data[w][s] : '0);
                end
                dispatch_rob_o[w].issue = 1'b1;
                dispatch_rob_o[w].areg  = in_pkg_i[w].areg;
                dispatch_rob_o[w].preg  = in_pkg_i[w].preg;
                dispatch_rob_o[w].pc    = in_pkg_i[w].pc;
                dispatch_rob_o[w].w_reg = in_pkg_i[w].w_reg;
                dispatch_rob_o[w].w_mem = in_pkg_i[w].w_mem;
            end
        end
        for (int k = 0; k < WAYS; k++) begin
            if (fire[k]) begin
                idx          = head_q[IDX_W-1:0] + IDX_W'(k);
                valid_d[idx] = 1'b0;
                fire_n       = fire_n + 1;
            end
        end
        head_d  = head_q + PTR_W'(fire_n);
        tail_d  = tail_q + PTR_W'(enq_n);
        count_d = count_q + PTR_W'(enq_n) - PTR_W'(fire_n);
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            valid_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            valid_q <= valid_d;
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= entry_d[i];
        end
    end
endmodule

// File: tb/tb_p_dispatch_mw.sv
// Directed bench for p_dispatch_mw: table of single-cycle vectors plus multi-cycle sequences.
module tb_p_dispatch_mw;
    import a_defines::*;
    localparam int WAYS = 2, DEPTH = 8, NPORT = 3, NCDB = 2;

    logic                            clk = 1'b0;
    logic                            rst, flush_i, in_ready_o;
    logic [WAYS-1:0]                 in_valid_i;
    rename_dispatch_pkg_t [WAYS-1:0] in_pkg_i;
    logic [WAYS-1:0][1:0][XLEN-1:0]  rob_data_i;
    logic [WAYS-1:0][1:0]            rob_complete_i;
    cdb_dispatch_pkg_t [NCDB-1:0]    cdb_i;
    dispatch_rob_pkg_t [WAYS-1:0]    dispatch_rob_o;
    logic [NPORT-1:0]                out_valid_o, out_ready_i;
    dispatch_issue_pkg_t [NPORT-1:0] out_pkg_o;

    p_dispatch_mw #(.WAYS(WAYS), .DEPTH(DEPTH), .NPORT(NPORT), .NCDB(NCDB)) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .in_valid_i(in_valid_i), .in_pkg_i(in_pkg_i),
        .in_ready_o(in_ready_o), .rob_data_i(rob_data_i), .rob_complete_i(rob_complete_i),
        .cdb_i(cdb_i), .dispatch_rob_o(dispatch_rob_o), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .out_pkg_o(out_pkg_o)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [1:0] in_valid;
        logic [1:0] p0, p1;
        logic [2:0] out_ready;
        logic       flush;
        logic       exp_in_ready;
        logic [2:0] exp_out_valid;
        logic [1:0] exp_issue;
    } vec_t;
    vec_t vecs [10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        flush_i = 0; in_valid_i = '0; in_pkg_i = '0; rob_data_i = '0;
        rob_complete_i = '0; cdb_i = '0; out_ready_i = '0;
    endtask

    task automatic set_way(input int w, input logic [1:0] port, input logic [31:0] pc);
        in_valid_i[w]       = 1'b1;
        in_pkg_i[w]         = '0;
        in_pkg_i[w].port    = port;
        in_pkg_i[w].pc      = pc;
        in_pkg_i[w].preg    = 6'(pc);
        in_pkg_i[w].w_reg   = 1'b1;
    endtask

    // Leave the clock edge and drive the next cycle's inputs at posedge+1.
    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_bits(output logic [1:0] b);
        b = {dispatch_rob_o[1].issue, dispatch_rob_o[0].issue};
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [1:0]  ib;
        logic [31:0] sb [$];
        logic [31:0] fired [3];
        logic [31:0] tmp, next_pc, want;
        int          nf;

        clear_inputs();
        rst = 1;
        advance(); advance();
        rst = 0;
        #2;
        issue_bits(ib);
        chk("reset_in_ready", in_ready_o, 1);
        chk("reset_out_valid", out_valid_o, 0);
        chk("reset_issue", ib, 0);
        $display("reset: in_ready=%0b out_valid=%b", in_ready_o, out_valid_o);
        advance();

        // in_valid, port0, port1, out_ready, flush | in_ready, out_valid, issue
        vecs[0] = '{2'b11, 2'd0, 2'd0, 3'b000, 1'b0, 1'b1, 3'b000, 2'b11};
        vecs[1] = '{2'b00, 2'd0, 2'd0, 3'b111, 1'b0, 1'b1, 3'b001, 2'b00};
        vecs[2] = '{2'b11, 2'd0, 2'd1, 3'b111, 1'b0, 1'b1, 3'b001, 2'b11};
        vecs[3] = '{2'b00, 2'd0, 2'd0, 3'b111, 1'b0, 1'b1, 3'b011, 2'b00};
        vecs[4] = '{2'b11, 2'd1, 2'd2, 3'b000, 1'b0, 1'b1, 3'b000, 2'b11};
        vecs[5] = '{2'b10, 2'd0, 2'd0, 3'b000, 1'b0, 1'b1, 3'b010, 2'b10};
        vecs[6] = '{2'b00, 2'd0, 2'd0, 3'b010, 1'b0, 1'b1, 3'b110, 2'b00};
        vecs[7] = '{2'b00, 2'd0, 2'd0, 3'b100, 1'b0, 1'b1, 3'b101, 2'b00};
        vecs[8] = '{2'b11, 2'd0, 2'd0, 3'b111, 1'b1, 1'b0, 3'b000, 2'b00};
        vecs[9] = '{2'b00, 2'd0, 2'd0, 3'b111, 1'b0, 1'b1, 3'b000, 2'b00};
        for (int v = 0; v < 10; v++) begin
            clear_inputs();
            if (vecs[v].in_valid[0]) set_way(0, vecs[v].p0, 32'(100 + 2*v));
            if (vecs[v].in_valid[1]) set_way(1, vecs[v].p1, 32'(101 + 2*v));
            out_ready_i = vecs[v].out_ready;
            flush_i     = vecs[v].flush;
            #2;
            issue_bits(ib);
            chk($sformatf("vec%0d_in_ready", v), in_ready_o, vecs[v].exp_in_ready);
            chk($sformatf("vec%0d_out_valid", v), out_valid_o, vecs[v].exp_out_valid);
            chk($sformatf("vec%0d_issue", v), ib, vecs[v].exp_issue);
            $display("vec %0d: in_ready=%0b out_valid=%b issue=%b", v, in_ready_o, out_valid_o, ib);
            advance();
        end

        // Fill to DEPTH with nothing draining, then confirm the extra pair is refused.
        for (int c = 0; c < 5; c++) begin
            clear_inputs();
            set_way(0, PORT_ALU, 32'(200 + 2*c));
            set_way(1, PORT_ALU, 32'(201 + 2*c));
            #2;
            issue_bits(ib);
            chk($sformatf("fill%0d_in_ready", c), in_ready_o, (c < 4) ? 1 : 0);
            chk($sformatf("fill%0d_issue", c), ib, (c < 4) ? 2'b11 : 2'b00);
            $display("fill %0d: in_ready=%0b issue=%b", c, in_ready_o, ib);
            advance();
        end
        clear_inputs();
        out_ready_i = 3'b111;
        for (int i = 0; i < 8; i++) begin
            #2;
            chk($sformatf("drain%0d_valid", i), out_valid_o, 3'b001);
            chk($sformatf("drain%0d_pc", i), out_pkg_o[0].pc, 200 + i);
            $display("drain %0d: pc=%0d", i, out_pkg_o[0].pc);
            advance();
        end
        #2;
        chk("drain_empty", out_valid_o, 0);
        advance();

        // Wakeup: source 0 waits on preg 5, source 1 already complete in the ROB.
        clear_inputs();
        set_way(0, PORT_ALU, 32'h500);
        in_pkg_i[0].src_preg[0] = 6'd5;
        in_pkg_i[0].src_preg[1] = 6'd7;
        rob_complete_i[0]       = 2'b10;
        rob_data_i[0][1]        = 32'h1234;
        advance();
        clear_inputs();
        #2;
        chk("wk_before_rdy", out_pkg_o[0].src_rdy, 2'b10);
        chk("wk_before_d1", out_pkg_o[0].src_data[1], 32'h1234);
        cdb_i[1].w_valid = 1'b1; cdb_i[1].w_preg = 6'd5; cdb_i[1].w_data = 32'hDEADBEEF;
        cdb_i[0].w_valid = 1'b1; cdb_i[0].w_preg = 6'd9; cdb_i[0].w_data = 32'hCAFEF00D;
        set_way(0, PORT_ALU, 32'h501);
        in_pkg_i[0].src_preg[0] = 6'd9;
        in_pkg_i[0].src_preg[1] = 6'd9;
        rob_complete_i[0]       = 2'b10;
        rob_data_i[0][1]        = 32'h7777;
        #1;
        chk("wk_bypass_rdy", out_pkg_o[0].src_rdy, 2'b11);
        chk("wk_bypass_d0", out_pkg_o[0].src_data[0], 32'hDEADBEEF);
        $display("wakeup bypass: rdy=%b d0=%h", out_pkg_o[0].src_rdy, out_pkg_o[0].src_data[0]);
        advance();
        clear_inputs();
        out_ready_i = 3'b001;
        #2;
        chk("wk_held_rdy", out_pkg_o[0].src_rdy, 2'b11);
        chk("wk_held_d0", out_pkg_o[0].src_data[0], 32'hDEADBEEF);
        chk("wk_held_pc", out_pkg_o[0].pc, 32'h500);
        advance();
        #2;
        chk("enq_cap_pc", out_pkg_o[0].pc, 32'h501);
        chk("enq_cap_rdy", out_pkg_o[0].src_rdy, 2'b11);
        chk("enq_cap_cdb", out_pkg_o[0].src_data[0], 32'hCAFEF00D);
        chk("enq_cap_rob_first", out_pkg_o[0].src_data[1], 32'h7777);
        $display("enqueue capture: d0=%h d1=%h", out_pkg_o[0].src_data[0], out_pkg_o[0].src_data[1]);
        advance();

        // Random enqueue/fire with wrapping pointers; age tags increase so order is checkable.
        clear_inputs();
        next_pc = 32'h1000;
        for (int c = 0; c < 40; c++) begin
            clear_inputs();
            in_valid_i = 2'($urandom_range(0, 3));
            for (int w = 0; w < WAYS; w++) begin
                in_pkg_i[w].port = 2'($urandom_range(0, 2));
                in_pkg_i[w].pc   = next_pc + 32'(w);
            end
            out_ready_i = 3'($urandom_range(0, 7));
            #2;
            nf = 0;
            for (int p = 0; p < NPORT; p++)
                if (out_valid_o[p] && out_ready_i[p]) begin fired[nf] = out_pkg_o[p].pc; nf++; end
            for (int a = 0; a < nf; a++)
                for (int b = 0; b + 1 < nf - a; b++)
                    if (fired[b] > fired[b+1]) begin tmp = fired[b]; fired[b] = fired[b+1]; fired[b+1] = tmp; end
            for (int a = 0; a < nf; a++) begin
                want = (sb.size() > 0) ? sb.pop_front() : 32'hFFFF_FFFF;
                chk("order", fired[a], want);
            end
            if (out_ready_i == 3'b111 && sb.size() + nf > 0) chk("progress", nf > 0, 1);
            if (in_ready_o)
                for (int w = 0; w < WAYS; w++)
                    if (in_valid_i[w]) sb.push_back(in_pkg_i[w].pc);
            if (in_ready_o && |in_valid_i) next_pc = next_pc + 2;
            $display("rand %0d: in_valid=%b in_ready=%0b fired=%0d queued=%0d", c, in_valid_i, in_ready_o, nf, sb.size());
            advance();
        end
        clear_inputs();
        out_ready_i = 3'b111;
        for (int c = 0; c < 40 && sb.size() > 0; c++) begin
            #2;
            nf = 0;
            for (int p = 0; p < NPORT; p++)
                if (out_valid_o[p]) begin fired[nf] = out_pkg_o[p].pc; nf++; end
            for (int a = 0; a < nf; a++)
                for (int b = 0; b + 1 < nf - a; b++)
                    if (fired[b] > fired[b+1]) begin tmp = fired[b]; fired[b] = fired[b+1]; fired[b+1] = tmp; end
            for (int a = 0; a < nf; a++) begin
                want = (sb.size() > 0) ? sb.pop_front() : 32'hFFFF_FFFF;
                chk("drain_order", fired[a], want);
            end
            advance();
        end
        chk("rand_drained", sb.size(), 0);
        #2;
        chk("rand_empty", out_valid_o, 0);
        advance();

        // Flush with six entries buffered.
        for (int c = 0; c < 3; c++) begin
            clear_inputs();
            set_way(0, PORT_ALU, 32'(300 + 2*c));
            set_way(1, PORT_LSU, 32'(301 + 2*c));
            advance();
        end
        clear_inputs();
        set_way(0, PORT_ALU, 32'h333);
        set_way(1, PORT_ALU, 32'h334);
        out_ready_i = 3'b111;
        flush_i = 1'b1;
        #2;
        issue_bits(ib);
        chk("flush_in_ready", in_ready_o, 0);
        chk("flush_out_valid", out_valid_o, 0);
        chk("flush_issue", ib, 0);
        $display("flush: in_ready=%0b out_valid=%b", in_ready_o, out_valid_o);
        advance();
        clear_inputs();
        out_ready_i = 3'b111;
        #2;
        chk("post_flush_valid", out_valid_o, 0);
        chk("post_flush_ready", in_ready_o, 1);
        set_way(0, PORT_MDU, 32'h900);
        out_ready_i = 3'b000;
        advance();
        clear_inputs();
        #2;
        chk("post_flush_enq_valid", out_valid_o, 3'b100);
        chk("post_flush_enq_pc", out_pkg_o[2].pc, 32'h900);
        advance();

        // Reset while full, with flush and enqueue also asserted.
        for (int c = 0; c < 4; c++) begin
            clear_inputs();
            set_way(0, PORT_ALU, 32'(400 + 2*c));
            set_way(1, PORT_LSU, 32'(401 + 2*c));
            advance();
        end
        clear_inputs();
        #2;
        chk("full_in_ready", in_ready_o, 0);
        set_way(0, PORT_ALU, 32'h444);
        set_way(1, PORT_ALU, 32'h445);
        rst = 1; flush_i = 1;
        #1;
        issue_bits(ib);
        chk("rst_issue", ib, 0);
        advance();
        clear_inputs();
        rst = 0;
        out_ready_i = 3'b111;
        #2;
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_in_ready", in_ready_o, 1);
        $display("mid reset: in_ready=%0b out_valid=%b", in_ready_o, out_valid_o);
        advance();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
